// File: rtl/stage_mem_pkg.sv
// Shared core definitions for the memory stage: opcodes, funct3 width codes,
// FSM state type and byte-lane helpers.
package stage_mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mem_state_e;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/stage_mem_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends
// according to the load width.
module mem_load_align
  import stage_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      F3_W:    data_o = shifted;
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Pipeline memory stage: issues LOAD/STORE on the data bus, stalls upstream
// until response, aligns load data. STAGE_MEM_ACCESS_FAULT_EN enables e_access_fault_o.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_data_i,
  input  logic        kill_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [2:0]  funct3_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_access_fault_o
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [1:0]       size;
  logic             is_load, is_store, addr_mis, up_flag;
  logic             start, timeout, fail, done;
  logic [31:0]      load_data;

  // pc/instruction/address are captured when the transfer starts, so the
  // aligner works from the registered copies while BUSY.
  mem_load_align u_align (
    .rdata_i   (dbus_dat_i),
    .addr_lo_i (alu_d_o[1:0]),
    .funct3_i  (funct3_o),
    .data_o    (load_data)
  );

  always_comb begin
    opcode   = instruction_i[6:0];
    funct3   = instruction_i[14:12];
    size     = funct3[1:0];
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    addr_mis = misaligned(size, alu_d_i[1:0]);
    up_flag  = e_illegal_inst_i || e_inst_addr_mis_i;
    start    = (state == S_IDLE) && valid_i && (is_load || is_store) &&
               !addr_mis && !up_flag && !kill_i;
    timeout  = (ACK_TIMEOUT != 0) && (cnt == CNT_W'(ACK_TIMEOUT - 1));
    // An ack arriving in the last allowed cycle wins over the timeout.
    fail     = dbus_err_i || (timeout && !dbus_ack_i);
    done     = dbus_ack_i || fail || kill_i;
    stall_o  = rst_i && (start || ((state == S_BUSY) && !done));
  end

`ifndef STAGE_MEM_ACCESS_FAULT_EN
  assign e_access_fault_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state             <= S_IDLE;
      cnt               <= '0;
      dbus_addr_o       <= '0;
      dbus_dat_o        <= '0;
      dbus_sel_o        <= '0;
      dbus_we_o         <= 1'b0;
      dbus_cyc_o        <= 1'b0;
      valid_o           <= 1'b0;
      pc_o              <= '0;
      instruction_o     <= '0;
      funct3_o          <= '0;
      alu_d_o           <= '0;
      mem_d_o           <= '0;
      e_illegal_inst_o  <= 1'b0;
      e_inst_addr_mis_o <= 1'b0;
      e_ld_addr_mis_o   <= 1'b0;
      e_st_addr_mis_o   <= 1'b0;
`ifdef STAGE_MEM_ACCESS_FAULT_EN
      e_access_fault_o  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt               <= '0;
          pc_o              <= pc_i;
          instruction_o     <= instruction_i;
          funct3_o          <= funct3;
          alu_d_o           <= alu_d_i;
          mem_d_o           <= '0;
          valid_o           <= valid_i && !kill_i && !start;
          e_illegal_inst_o  <= 1'b0;
          e_inst_addr_mis_o <= 1'b0;
          e_ld_addr_mis_o   <= 1'b0;
          e_st_addr_mis_o   <= 1'b0;
`ifdef STAGE_MEM_ACCESS_FAULT_EN
          e_access_fault_o  <= 1'b0;
`endif
          if (start) begin
            state       <= S_BUSY;
            dbus_cyc_o  <= 1'b1;
            dbus_addr_o <= {alu_d_i[31:2], 2'b00};
            dbus_sel_o  <= lane_sel(size, alu_d_i[1:0]);
            dbus_dat_o  <= store_lanes(size, st_data_i);
            dbus_we_o   <= is_store;
          end else if (valid_i && !kill_i) begin
            e_illegal_inst_o  <= e_illegal_inst_i;
            e_inst_addr_mis_o <= !e_illegal_inst_i && e_inst_addr_mis_i;
            e_ld_addr_mis_o   <= !up_flag && is_load && addr_mis;
            e_st_addr_mis_o   <= !up_flag && is_store && addr_mis;
          end
        end
        S_BUSY: begin
          if (kill_i) begin
            state      <= S_IDLE;
            dbus_cyc_o <= 1'b0;
            dbus_we_o  <= 1'b0;
            valid_o    <= 1'b0;
          end else if (done) begin
            state      <= S_IDLE;
            dbus_cyc_o <= 1'b0;
            dbus_we_o  <= 1'b0;
            valid_o    <= 1'b1;
            mem_d_o    <= (fail || dbus_we_o) ? '0 : load_data;
`ifdef STAGE_MEM_ACCESS_FAULT_EN
            e_access_fault_o <= fail;
`endif
          end else if (cnt != CNT_W'(ACK_TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed instruction vectors, a
// specification-level model and a per-cycle compare process.
module tb_stage_mem;

  localparam int TO = 4;
`ifdef STAGE_MEM_ACCESS_FAULT_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif
  localparam logic [6:0] LD  = 7'h03;
  localparam logic [6:0] ST  = 7'h23;
  localparam logic [6:0] ALU = 7'h33;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, kill_i, e_illegal_inst_i, e_inst_addr_mis_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, st_data_i;
  logic [31:0] dbus_addr_o, dbus_dat_o, dbus_dat_i;
  logic [3:0]  dbus_sel_o;
  logic        dbus_we_o, dbus_cyc_o, dbus_ack_i, dbus_err_i;
  logic        stall_o, valid_o;
  logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o;
  logic [2:0]  funct3_o;
  logic        e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o;
  logic        e_access_fault_o;

  stage_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .instruction_i(instruction_i), .alu_d_i(alu_d_i), .st_data_i(st_data_i),
    .kill_i(kill_i), .e_illegal_inst_i(e_illegal_inst_i),
    .e_inst_addr_mis_i(e_inst_addr_mis_i), .dbus_addr_o(dbus_addr_o),
    .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o), .dbus_we_o(dbus_we_o),
    .dbus_cyc_o(dbus_cyc_o), .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i),
    .dbus_err_i(dbus_err_i), .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o),
    .instruction_o(instruction_o), .funct3_o(funct3_o), .alu_d_o(alu_d_o),
    .mem_d_o(mem_d_o), .e_illegal_inst_o(e_illegal_inst_o),
    .e_inst_addr_mis_o(e_inst_addr_mis_o), .e_ld_addr_mis_o(e_ld_addr_mis_o),
    .e_st_addr_mis_o(e_st_addr_mis_o), .e_access_fault_o(e_access_fault_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state for the current cycle, written by the driver just after each rising edge.
  bit          chk_en = 1'b0;
  bit          exp_stall = 1'b0, exp_cyc = 1'b0, exp_we = 1'b0, exp_v = 1'b0;
  logic [31:0] exp_addr = '0, exp_dat = '0, exp_pc = '0, exp_ins = '0, exp_alu = '0, exp_mem = '0;
  logic [3:0]  exp_sel = '0;
  logic [2:0]  exp_f3 = '0;
  logic [4:0]  exp_exc = '0;
  int          stall_cnt = 0;
  bit          cyc_seen = 1'b0;
  logic [3:0]  cap_sel = '0;
  logic [31:0] cap_dat = '0;
  logic        cap_we = 1'b0;

  always @(negedge clk_i) begin
    if (stall_o) stall_cnt++;
    if (dbus_cyc_o) begin
      cyc_seen = 1'b1;
      cap_sel  = dbus_sel_o;
      cap_dat  = dbus_dat_o;
      cap_we   = dbus_we_o;
    end
    if (chk_en) begin
      check("stall_o", stall_o, exp_stall);
      check("dbus_cyc_o", dbus_cyc_o, exp_cyc);
      if (exp_cyc) begin
        check("dbus_addr_o", dbus_addr_o, exp_addr);
        check("dbus_sel_o", dbus_sel_o, exp_sel);
        check("dbus_we_o", dbus_we_o, exp_we);
        if (exp_we) check("dbus_dat_o", dbus_dat_o, exp_dat);
      end
      check("valid_o", valid_o, exp_v);
      if (exp_v) begin
        check("pc_o", pc_o, exp_pc);
        check("instruction_o", instruction_o, exp_ins);
        check("funct3_o", funct3_o, exp_f3);
        check("alu_d_o", alu_d_o, exp_alu);
        check("mem_d_o", mem_d_o, exp_mem);
      end
      check("e_illegal_inst_o", e_illegal_inst_o, exp_exc[4]);
      check("e_inst_addr_mis_o", e_inst_addr_mis_o, exp_exc[3]);
      check("e_ld_addr_mis_o", e_ld_addr_mis_o, exp_exc[2]);
      check("e_st_addr_mis_o", e_st_addr_mis_o, exp_exc[1]);
      check("e_access_fault_o", e_access_fault_o, exp_exc[0]);
    end
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr, st, rdata;
    int          lat;      // cycles of dbus_cyc_o up to the response; 0 = never
    int          resp;     // 0 ack, 1 err, 2 ack+err
    bit          ill, imis;
    int          kill_at;  // -1 none, 0 at issue, k = k-th bus cycle
  } vec_t;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] st, input logic [31:0] rdata, input int lat,
                              input int resp, input bit ill, input bit imis, input int kill_at);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.st = st; v.rdata = rdata; v.lat = lat;
    v.resp = resp; v.ill = ill; v.imis = imis; v.kill_at = kill_at;
    return v;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_sel(input int nb, input logic [31:0] a);
    logic [31:0] s;
    s = ((32'd1 << nb) - 32'd1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_dat(input int nb, input logic [31:0] d);
    if (nb == 1) return (d % 256) * 32'h0101_0101;
    if (nb == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    exp_v   = 1'b0;
    exp_exc = '0;
  endtask

  // Runs one instruction; returns in its output cycle (after the registering edge).
  task automatic run(input vec_t v);
    logic [31:0] ins;
    bit is_ld, is_st, mis, bus, killed, timed_out, fault;
    int nb, end_k, resp_k;
    ins    = {12'hABC, 5'd3, v.f3, 5'd7, v.op};
    is_ld  = (v.op == LD);
    is_st  = (v.op == ST);
    nb     = nbytes(v.f3);
    mis    = (is_ld || is_st) && (v.addr % nb != 0);
    bus    = (is_ld || is_st) && !mis && !v.ill && !v.imis && (v.kill_at != 0);
    killed = 1'b0; timed_out = 1'b0; resp_k = 0;
    step();
    stall_cnt = 0; cyc_seen = 1'b0;
    valid_i = 1'b1; instruction_i = ins; pc_i = 32'h8000_0000 | v.addr;
    alu_d_i = v.addr; st_data_i = v.st; e_illegal_inst_i = v.ill;
    e_inst_addr_mis_i = v.imis; kill_i = (v.kill_at == 0);
    dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
    exp_stall = bus; exp_cyc = 1'b0;
    if (bus) begin
      resp_k    = (v.lat == 0 || v.lat > TO) ? 0 : v.lat;
      end_k     = (resp_k == 0) ? TO : resp_k;
      killed    = (v.kill_at > 0) && (v.kill_at <= end_k);
      if (killed) end_k = v.kill_at;
      timed_out = (resp_k == 0) && !killed;
      for (int k = 1; k <= end_k; k++) begin
        step();
        exp_cyc  = 1'b1;
        exp_addr = v.addr - (v.addr % 4);
        exp_sel  = m_sel(nb, v.addr);
        exp_dat  = m_dat(nb, v.st);
        exp_we   = is_st;
        dbus_ack_i = (k == resp_k) && (v.resp != 1);
        dbus_err_i = (k == resp_k) && (v.resp != 0);
        dbus_dat_i = (k == resp_k) ? v.rdata : 32'h0BAD_F00D;
        kill_i     = (k == v.kill_at);
        exp_stall  = (k != end_k);
      end
    end
    step();
    valid_i = 1'b0; kill_i = 1'b0; dbus_err_i = 1'b0;
    dbus_ack_i = killed;  // late response after a kill must be ignored
    exp_cyc = 1'b0; exp_stall = 1'b0; exp_we = 1'b0;
    if (!killed && v.kill_at != 0) begin
      fault   = bus && (timed_out || (resp_k != 0 && v.resp != 0));
      exp_v   = 1'b1;
      exp_pc  = 32'h8000_0000 | v.addr;
      exp_ins = ins;
      exp_f3  = v.f3;
      exp_alu = v.addr;
      exp_mem = (bus && is_ld && !fault) ? m_load(v.f3, v.addr, v.rdata) : 32'h0;
      if (v.ill)              exp_exc = 5'b10000;
      else if (v.imis)        exp_exc = 5'b01000;
      else if (mis && is_ld)  exp_exc = 5'b00100;
      else if (mis && is_st)  exp_exc = 5'b00010;
      else if (fault && AF)   exp_exc = 5'b00001;
      else                    exp_exc = 5'b00000;
    end
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; kill_i = 1'b0; e_illegal_inst_i = 1'b0;
    e_inst_addr_mis_i = 1'b0; pc_i = '0; instruction_i = '0; alu_d_i = '0;
    st_data_i = '0; dbus_dat_i = '0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0;

    vecs.push_back(mk(ALU, 3'd6, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0, 0, -1));         // 0
    vecs.push_back(mk(LD, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 0, -1));        // 1
    vecs.push_back(mk(LD, 3'd0, 32'h103, 32'h0, 32'h8000_0000, 1, 0, 0, 0, -1));        // 2
    vecs.push_back(mk(LD, 3'd4, 32'h103, 32'h0, 32'h8000_0000, 2, 0, 0, 0, -1));        // 3
    vecs.push_back(mk(ST, 3'd1, 32'h202, 32'h1234, 32'h0, 1, 0, 0, 0, -1));             // 4
    vecs.push_back(mk(LD, 3'd2, 32'h101, 32'h0, 32'h0, 1, 0, 0, 0, -1));                // 5
    vecs.push_back(mk(ST, 3'd2, 32'h102, 32'hCAFE_0001, 32'h0, 1, 0, 0, 0, -1));        // 6
    vecs.push_back(mk(LD, 3'd1, 32'h202, 32'h0, 32'h8001_0000, 2, 0, 0, 0, -1));        // 7
    vecs.push_back(mk(LD, 3'd5, 32'h202, 32'h0, 32'h8001_0000, 1, 0, 0, 0, -1));        // 8
    vecs.push_back(mk(LD, 3'd0, 32'h102, 32'h0, 32'h0012_0000, 1, 0, 0, 0, -1));        // 9
    vecs.push_back(mk(ST, 3'd0, 32'h101, 32'hA5, 32'h0, 2, 0, 0, 0, -1));               // 10
    vecs.push_back(mk(ST, 3'd2, 32'h104, 32'h1122_3344, 32'h0, 1, 0, 0, 0, -1));        // 11
    vecs.push_back(mk(LD, 3'd2, 32'h101, 32'h0, 32'h0, 1, 0, 1, 0, -1));                // 12
    vecs.push_back(mk(ST, 3'd2, 32'h101, 32'h0, 32'h0, 1, 0, 0, 1, -1));                // 13
    vecs.push_back(mk(LD, 3'd2, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0, -1));                // 14
    vecs.push_back(mk(ST, 3'd0, 32'h301, 32'h55, 32'h0, 2, 1, 0, 0, -1));               // 15
    vecs.push_back(mk(LD, 3'd2, 32'h304, 32'h0, 32'h1234_5678, 1, 2, 0, 0, -1));        // 16
    vecs.push_back(mk(LD, 3'd2, 32'h308, 32'h0, 32'h5555, 0, 0, 0, 0, 2));              // 17
    vecs.push_back(mk(LD, 3'd2, 32'h30C, 32'h0, 32'h6666, 2, 0, 0, 0, 2));              // 18
    vecs.push_back(mk(ALU, 3'd0, 32'h40, 32'h0, 32'h0, 0, 0, 0, 0, 0));                 // 19
    vecs.push_back(mk(LD, 3'd2, 32'h310, 32'h0, 32'h7777_7777, 4, 0, 0, 0, -1));        // 20

    #3;
    check("rst valid_o", valid_o, 1'b0);
    check("rst dbus_cyc_o", dbus_cyc_o, 1'b0);
    check("rst stall_o", stall_o, 1'b0);
    check("rst pc_o", pc_o, 32'h0);
    check("rst alu_d_o", alu_d_o, 32'h0);
    check("rst mem_d_o", mem_d_o, 32'h0);
    check("rst dbus_sel_o", dbus_sel_o, 4'h0);
    check("rst e_access_fault_o", e_access_fault_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    chk_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i]);
      case (i)
        1: begin
          check("lw mem_d literal", mem_d_o, 32'hDEAD_BEEF);
          check("lw stall cycles", stall_cnt, 3);
        end
        2: begin
          check("lb sel literal", cap_sel, 4'b1000);
          check("lb mem_d literal", mem_d_o, 32'hFFFF_FF80);
        end
        3: check("lbu mem_d literal", mem_d_o, 32'h0000_0080);
        4: begin
          check("sh sel literal", cap_sel, 4'b1100);
          check("sh dat literal", cap_dat, 32'h1234_1234);
          check("sh we literal", cap_we, 1'b1);
        end
        5: begin
          check("lw mis flag literal", e_ld_addr_mis_o, 1'b1);
          check("lw mis alu_d literal", alu_d_o, 32'h101);
          check("lw mis no bus", cyc_seen, 1'b0);
        end
        7: check("lh mem_d literal", mem_d_o, 32'hFFFF_8001);
        10: check("sb dat literal", cap_dat, 32'hA5A5_A5A5);
        14: begin
          check("timeout stall cycles", stall_cnt, 4);
          check("timeout fault literal", e_access_fault_o, AF);
          check("timeout valid literal", valid_o, 1'b1);
        end
        17: begin
          check("kill valid literal", valid_o, 1'b0);
          check("kill cyc literal", dbus_cyc_o, 1'b0);
        end
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of a bus transfer.
    step();
    chk_en = 1'b0;
    dbus_ack_i = 1'b0;
    valid_i = 1'b1; instruction_i = {12'hABC, 5'd3, 3'd2, 5'd7, LD};
    alu_d_i = 32'h400; kill_i = 1'b0; e_illegal_inst_i = 1'b0; e_inst_addr_mis_i = 1'b0;
    step();
    check("pre-reset cyc", dbus_cyc_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    check("async reset cyc", dbus_cyc_o, 1'b0);
    check("async reset stall", stall_o, 1'b0);
    check("async reset valid", valid_o, 1'b0);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    dbus_ack_i = 1'b1;
    dbus_dat_i = 32'h1357_9BDF;
    step();
    dbus_ack_i = 1'b0;
    check("post-reset ack valid", valid_o, 1'b0);
    check("post-reset ack cyc", dbus_cyc_o, 1'b0);
    check("post-reset ack mem_d", mem_d_o, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
